// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: pipeline control inputs, instruction SRAM request,
// the IF->ID bus and the fetch FSM state for observation.
interface if_fetch_unit_if #(
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               fifo_full;
  logic               flush;
  logic [31:0]        new_pc;
  logic [33:0]        br_bus;
  logic               inst_sram_en;
  logic [7:0]         inst_sram_wen;
  logic [31:0]        inst_sram_addr;
  logic [63:0]        inst_sram_wdata;
  logic [33:0]        if_to_id_bus;
  logic [1:0]         fetch_state;

  // No valid/ready pairs here: a fetch is issued whenever inst_sram_en is high,
  // and if_to_id_bus is meaningful whenever its ce bit is set.
  modport master (
    input  stall, fifo_full, flush, new_pc, br_bus,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
           if_to_id_bus, fetch_state
  );

  modport slave (
    output stall, fifo_full, flush, new_pc, br_bus,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
           if_to_id_bus, fetch_state
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 64-bit pair fetches and tracks
// delayed branch redirection across delay slots and stalls.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFF8,
  parameter int          STALL_W  = 6
) (
  input logic             clk,
  input logic             rst,
  if_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DS_WAIT = 2'd1,
    ST_PEND    = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] pend_tgt;
  logic        ce;
  logic [31:0] next_pc;
  logic [31:0] seq_pc;
  logic        hold;
  logic        br_e;
  logic        br_slot2;
  logic [31:0] br_addr;
  logic        adel;
  logic        stall_unused;

  assign {br_e, br_slot2, br_addr} = bus.br_bus;
  assign hold         = bus.stall[0] | bus.fifo_full;
  assign stall_unused = ^bus.stall[STALL_W-1:1];
  assign seq_pc       = pc_reg + 32'd8;

  always_comb begin
    next_pc = seq_pc;
    if (bus.flush)
      next_pc = bus.new_pc;
    else if (state == ST_PEND && !hold)
      next_pc = pend_tgt;
    else if (state == ST_DS_WAIT)
      next_pc = seq_pc;
    else if (br_e && !br_slot2)
      next_pc = br_addr;
  end

  assign bus.inst_sram_en    = rst & (~hold | bus.flush);
  assign bus.inst_sram_wen   = 8'd0;
  assign bus.inst_sram_addr  = next_pc;
  assign bus.inst_sram_wdata = 64'd0;
  assign bus.fetch_state     = state;

  // A misaligned PC is still presented so ID can raise the address error.
  assign adel             = (pc_reg[1:0] != 2'b00) & ce;
  assign bus.if_to_id_bus = ce ? {adel, 1'b1, pc_reg} : 34'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg   <= RESET_PC;
      ce       <= 1'b0;
      state    <= ST_RUN;
      pend_tgt <= 32'd0;
    end else if (bus.flush) begin
      pc_reg   <= bus.new_pc;
      ce       <= 1'b1;
      state    <= ST_RUN;
      pend_tgt <= 32'd0;
    end else begin
      if (!hold) begin
        pc_reg <= next_pc;
        ce     <= 1'b1;
      end
      case (state)
        ST_RUN: begin
          // A slot-2 branch needs its delay-slot pair fetched before the target.
          if (br_e && br_slot2) begin
            state    <= ST_DS_WAIT;
            pend_tgt <= br_addr;
          end else if (br_e && hold) begin
            state    <= ST_PEND;
            pend_tgt <= br_addr;
          end
        end
        ST_DS_WAIT: if (!hold) state <= ST_PEND;
        ST_PEND:    if (!hold) state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end
endmodule
